rv32i_dmem_responder: RTL and testbench

RV32I_DMEM_RESPONDER -- requirements
Module: rv32i_dmem_responder

---
 rtl/rv32i_dmem_pkg.sv | 47 ++++
 rtl/rv32i_dmem_bank.sv | 28 ++
 rtl/rv32i_dmem_responder.sv | 107 ++++++++++
 tb/tb_rv32i_dmem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_dmem_pkg.sv
// Shared types for the RV32I data-memory responder: FSM states, request struct, legal byte enables.
// The RV32I_DMEM_ERR_EN build uses be_legal() to reject misaligned or unsupported write masks.
package rv32i_dmem_pkg;

    localparam logic [1:0] ST_IDLE_C = 2'd0;
    localparam logic [1:0] ST_WAIT_C = 2'd1;
    localparam logic [1:0] ST_RESP_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_C,
        ST_WAIT = ST_WAIT_C,
        ST_RESP = ST_RESP_C
    } dmem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // A mask is legal when it is a byte, aligned half or word whose lowest lane matches addr[1:0].
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0:   ok = (lo == 2'd0);
            BE_B1:   ok = (lo == 2'd1);
            BE_B2:   ok = (lo == 2'd2);
            BE_B3:   ok = (lo == 2'd3);
            BE_H0:   ok = (lo == 2'd0);
            BE_H1:   ok = (lo == 2'd2);
            BE_W:    ok = (lo == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_dmem_bank.sv
// Byte-enabled synchronous single-port RAM, DEPTH_WORDS x 32. Contents are never reset.
module rv32i_dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Wait-state data-memory responder: accept in IDLE, count WAIT_CYCLES, commit/read, hold response.
// Define RV32I_DMEM_ERR_EN to add the rsp_err port and byte-enable legality checking on writes.
module rv32i_dmem_responder
    import rv32i_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
`ifdef RV32I_DMEM_ERR_EN
    output logic        rsp_err,
`endif
    output logic [31:0] rsp_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e state;
    logic [3:0]  cnt;
    dmem_req_t   req_q;
    dmem_req_t   cur;
    logic        accept;
    logic        commit;
    logic        wr_en;
    logic        req_err;
    logic [31:0] bank_rdata;
    logic        unused_addr_bits;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // The zero-wait path commits on the accept edge, so the bank must see the live request then.
    always_comb begin
        cur = req_q;
        if (state == ST_IDLE)
            cur = '{addr: req_addr, we: req_we, be: req_be, wdata: req_wdata};
    end

    assign commit = !reset &&
                    ((accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (cnt <= 4'd1)));

`ifdef RV32I_DMEM_ERR_EN
    logic err_q;
    assign req_err = cur.we && !be_legal(cur.be, cur.addr[1:0]);
    assign rsp_err = (state == ST_RESP) && err_q;

    always_ff @(posedge clk) begin
        if (reset)       err_q <= 1'b0;
        else if (commit) err_q <= req_err;
    end
`else
    assign req_err = 1'b0;
`endif

    assign wr_en = cur.we && !req_err;
    assign unused_addr_bits = ^{cur.addr[31:AW+2], cur.addr[1:0]};

    rv32i_dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk   (clk),
        .en    (commit),
        .we    (wr_en),
        .be    (cur.be),
        .idx   (cur.addr[2 +: AW]),
        .wdata (cur.wdata),
        .rdata (bank_rdata)
    );

    assign rsp_rdata = (state == ST_RESP && !req_q.we) ? bank_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    req_q <= cur;
                    if (WAIT_CYCLES == 0) begin
                        state <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                // Counter reaching zero on this edge is the WAIT->RESP transition.
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Self-checking bench for rv32i_dmem_responder: directed scenarios plus randomized traffic vs a word/byte model.
module tb_rv32i_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [DEPTH];

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
`ifdef RV32I_DMEM_ERR_EN
        .rsp_err   (rsp_err),
`endif
        .rsp_rdata (rsp_rdata)
    );

`ifndef RV32I_DMEM_ERR_EN
    assign rsp_err = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Legal masks are single bytes, aligned halves or the full word; the lowest enabled lane must be addr[1:0].
    function automatic bit exp_err(input bit we, input logic [3:0] be, input logic [31:0] a);
`ifdef RV32I_DMEM_ERR_EN
        int low;
        bit in_set;
        if (!we) return 1'b0;
        in_set = (be == 4'd1) || (be == 4'd2) || (be == 4'd4) || (be == 4'd8) ||
                 (be == 4'd3) || (be == 4'd12) || (be == 4'd15);
        low = -1;
        for (int i = 3; i >= 0; i--) if (be[i]) low = i;
        return !(in_set && low == int'(a[1:0]));
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[widx(a)][8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Present one request, wait for rsp_valid; lat counts clock edges from the accept edge inclusive.
    task automatic issue(input logic [31:0] a, input bit we, input logic [3:0] be,
                         input logic [31:0] wd, input bit keep, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        if (!req_ready) begin
            errors++; checks++;
            $display("FAIL issue_ready_timeout got=%0b want=1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        if (!rsp_valid) begin
            errors++; checks++;
            $display("FAIL issue_rsp_timeout got=%0b want=1", rsp_valid);
        end
        if (we && !exp_err(we, be, a)) model_write(a, be, wd);
    endtask

    task automatic take(input int delay);
        repeat (delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic [31:0] a, input bit we, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
        issue(a, we, be, wd, 1'b0, lat);
        rd = rsp_rdata;
        er = rsp_err;
        take(0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    endtask

    task automatic test_basic;
        int lat; logic [31:0] rd; logic er;
        xact(32'h50, 1'b1, 4'b1111, 32'h0, lat, rd, er);
        xact(32'h50, 1'b1, 4'b0001, 32'h80, lat, rd, er);
        checks++; if (lat != WAITC + 1) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, WAITC + 1); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL basic_write_rdata got=%h want=0", rd); end
        xact(32'h50, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h80) begin errors++; $display("FAIL basic_read got=%h want=00000080", rd); end
    endtask

    task automatic test_merge;
        int lat; logic [31:0] rd; logic er;
        xact(32'h54, 1'b1, 4'b1111, 32'h12345678, lat, rd, er);
        xact(32'h56, 1'b1, 4'b0100, 32'h00AB0000, lat, rd, er);
        xact(32'h56, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h12AB5678) begin errors++; $display("FAIL merge_read got=%h want=12ab5678", rd); end
    endtask

    task automatic test_hold;
        int lat; logic [31:0] rd0;
        issue(32'h54, 1'b0, 4'b0000, 32'h0, 1'b1, lat);
        rd0 = rsp_rdata;
        checks++; if (rd0 !== mem_m[widx(32'h54)]) begin errors++; $display("FAIL hold_rdata got=%h want=%h", rd0, mem_m[widx(32'h54)]); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         i, rsp_valid, rsp_rdata, req_ready, rd0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_accept got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic er;
        xact(32'h1000, 1'b1, 4'b1111, 32'hDEADBEEF, lat, rd, er);
        xact(32'h0000, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_read got=%h want=deadbeef", rd); end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rd; logic er;
        xact(32'h60, 1'b1, 4'b1111, 32'h5A5A1234, lat, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h60; req_we = 1'b1; req_be = 4'b1111; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        end
        repeat (4) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got=%b want=0", rsp_valid); end
        xact(32'h60, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h5A5A1234) begin errors++; $display("FAIL abort_mem got=%h want=5a5a1234", rd); end
    endtask

    task automatic test_err;
`ifdef RV32I_DMEM_ERR_EN
        int lat; logic [31:0] rd; logic er;
        xact(32'h60, 1'b1, 4'b1111, 32'h11223344, lat, rd, er);
        xact(32'h62, 1'b1, 4'b0011, 32'h0000BEEF, lat, rd, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_bad_be got=%b want=1", er); end
        xact(32'h60, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL err_mem_unchanged got=%h want=11223344", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_read got=%b want=0", er); end
        xact(32'h62, 1'b1, 4'b1100, 32'hCAFE0000, lat, rd, er);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_good_be got=%b want=0", er); end
        xact(32'h60, 1'b0, 4'b0000, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hCAFE3344) begin errors++; $display("FAIL err_good_mem got=%h want=cafe3344", rd); end
`endif
    endtask

    task automatic test_random;
        int pool [8];
        int lat;
        logic [31:0] a, wd, rd, want;
        logic [3:0] be;
        logic er;
        bit we, ee;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32 + i * 37;
            xact(32'(pool[i] * 4), 1'b1, 4'b1111, $urandom, lat, rd, er);
        end
        for (int n = 0; n < 150; n++) begin
            a  = 32'(pool[$urandom_range(0, 7)] * 4) + 32'($urandom_range(0, 7) * DEPTH * 4) + 32'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            ee = exp_err(we, be, a);
            want = we ? 32'd0 : mem_m[widx(a)];
            issue(a, we, be, wd, 1'b0, lat);
            rd = rsp_rdata;
            er = rsp_err;
            take($urandom_range(0, 3));
            checks++;
            if (lat != WAITC + 1 || rd !== want || er !== ee) begin
                errors++;
                $display("FAIL rand n=%0d a=%h we=%0b be=%b got lat=%0d d=%h e=%b want lat=%0d d=%h e=%b",
                         n, a, we, be, lat, rd, er, WAITC + 1, want, ee);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_basic;
        test_merge;
        test_hold;
        test_wrap;
        test_reset_abort;
        test_err;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
